mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, data bus width.
REQ-002 Parameter: ADDR_W, 32, address bus width.
REQ-003 Parameter: TIMEOUT_CYC, 15, maximum BUSY cycles allowed while waiting for mem_ready.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 cpu_req / cpu_we  in  1 / 1  CPU access request / write select.
REQ-007 cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address / write data.
REQ-008 cpu_rdata / cpu_ack / cpu_err  out  DATA_W / 1 / 1  CPU read data / completion pulse / timeout flag.
REQ-009 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack, dbg_err: debug-loader port, same directions and widths as the CPU port.
REQ-010 mem_en / mem_we  out  1 / 1  memory access enable / write.
REQ-011 mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address / write data.
REQ-012 mem_rdata / mem_ready  in  DATA_W / 1  memory read data / access complete.

Function
REQ-013 FSM states: IDLE, BUSY, ACK.
REQ-014 IDLE: no req -> stay; any req -> BUSY, with the owner latched and the winning request's we/addr/wdata registered onto mem_*.
REQ-015 Fixed priority: dbg wins when both requests are asserted in the same IDLE cycle.
REQ-016 BUSY: mem_en=1, mem_* held stable; mem_ready=1 -> ACK, registering mem_rdata (reads) into the owner's rdata.
REQ-017 BUSY: the timeout counter starts at 0 on BUSY entry and increments each cycle without mem_ready.
REQ-018 When the counter reaches TIMEOUT_CYC-1 without mem_ready -> ACK with err set and owner rdata = 0.
REQ-019 ACK: owner ack=1 for exactly one cycle, err valid in that cycle; next state IDLE; mem_en=0.
REQ-020 The non-owner ack/err stay 0 throughout.
REQ-021 Requester protocol: hold req and payload until ack; deassert req in the ack cycle.
REQ-022 req dropped during BUSY: the transaction still completes and ack is still issued.
REQ-023 rdata holds its last value until the next completion for that port; it is not updated on writes.
REQ-024 Latency: req seen in IDLE at cycle N; mem_en from N+1; mem_ready at cycle M (M>=N+1); ack at M+1.
REQ-025 Minimum transaction length: 3 cycles.
REQ-026 mem_ready outside BUSY is ignored.
REQ-027 A req arriving during BUSY or ACK waits for IDLE.

Reset
REQ-028 Asynchronous reset, including mid-transaction, forces: state IDLE, counter 0, owner CPU.
REQ-029 Asynchronous reset forces all outputs to 0: mem_en, mem_we, mem_addr, mem_wdata, both acks, both errs, both rdata.
REQ-030 An in-flight transaction is abandoned with no ack; the first arbitration happens in the first IDLE cycle after reset deasserts.

Configuration
REQ-031 Macro MEM_ARB_RR_EN defined: round-robin; on simultaneous requests the port not granted last wins; the last-grant pointer resets to CPU, so dbg wins the first tie.
REQ-032 Macro MEM_ARB_RR_EN undefined: fixed priority per REQ-015, with no pointer register.

Structure
REQ-033 Package mem_arb_pkg holds the state enum (IDLE/BUSY/ACK), the owner encoding (OWN_CPU=0, OWN_DBG=1) and the default TIMEOUT_CYC.
REQ-034 One sub-module, mem_arb_timer: a loadable timeout counter with clear and expired outputs.

Verification
REQ-035 Single CPU read, addr 0x40, memory returns 0xDEADBEEF with mem_ready 1 cycle after mem_en -> cpu_ack 3 cycles after req, cpu_rdata=0xDEADBEEF, cpu_err=0.
REQ-036 CPU write, addr 0x10, wdata 0x12345678, mem_ready delayed 4 cycles -> mem_addr/mem_wdata stable all 4 BUSY cycles, then one cpu_ack pulse.
REQ-037 cpu_req and dbg_req asserted in the same cycle, repeated 4 times -> dbg,dbg,dbg,dbg without the macro; dbg,cpu,dbg,cpu with MEM_ARB_RR_EN.
REQ-038 mem_ready never asserted, TIMEOUT_CYC=15 -> ack with err=1 and rdata=0 after 15 BUSY cycles, then IDLE.
REQ-039 reset pulsed in the 2nd BUSY cycle of a dbg read -> all outputs 0 immediately, no dbg_ack, and a pending cpu_req is granted after reset deasserts.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and defaults for the memory port arbiter.
//   arb_state_e     : arbiter FSM states (IDLE, BUSY, ACK)
//   owner_e         : which requester owns the memory port (OWN_CPU=0, OWN_DBG=1)
//   DEF_TIMEOUT_CYC : default number of BUSY cycles allowed before giving up
//   other_owner()   : the port that is not the given one
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  localparam int DEF_TIMEOUT_CYC = 15;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_CPU) ? OWN_DBG : OWN_CPU;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer -- timeout counter for the BUSY phase of the arbiter.
// The count is loaded with zero by clear and advances by one on each cycle
// with en set, saturating at LIMIT-1, where expired is raised.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   clear      : load the count with 0 (wins over en)
//   en         : advance the count by one
//   expired    : count has reached LIMIT-1
// LIMIT must be at least 1.
module mem_arb_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter -- shares one memory port between a CPU and a debug loader.
//
// Handshake (both requester ports): a requester raises req with we/addr/wdata
// and holds them until it sees a one-cycle ack; it drops req in the ack cycle.
// err is valid only in the ack cycle (set on timeout). rdata holds the data of
// that port's last completed read. On the memory side mem_en is held high with
// a stable payload until mem_ready is seen; mem_ready outside BUSY is ignored.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata  (in)      CPU request and payload
//   cpu_rdata/ack/err      (out)     CPU read data, completion pulse, timeout flag
//   dbg_*                            debug-loader port, same as CPU port
//   mem_en/we/addr/wdata   (out)     memory access, registered and held in BUSY
//   mem_rdata/ready        (in)      memory read data and completion
//   state_dbg              (out)     current FSM state (arb_state_e encoding)
//
// Configuration: define MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise the debug port always wins a tie.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        state_dbg
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            win;
  logic              any_req;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic              cpu_err_q, cpu_err_d;
  logic              dbg_err_q, dbg_err_d;
  logic              timer_clear, timer_en, timer_expired;
  logic              done, timed_out;
  logic [DATA_W-1:0] done_data;

  assign any_req = cpu_req | dbg_req;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
  // last_grant starts at CPU so the debug port wins the first tie.
  owner_e last_grant_q, last_grant_d;

  always_comb begin
    if (cpu_req && dbg_req) begin
      win = other_owner(last_grant_q);
    end else begin
      win = dbg_req ? OWN_DBG : OWN_CPU;
    end
    last_grant_d = last_grant_q;
    if (state_q == IDLE && any_req) begin
      last_grant_d = win;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= OWN_CPU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  always_comb begin
    win = dbg_req ? OWN_DBG : OWN_CPU;
  end
`endif

  // ---------------------------------------------------------------------
  // Timeout counter: cleared on BUSY entry, advances on each BUSY cycle
  // without mem_ready.
  // ---------------------------------------------------------------------
  mem_arb_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // A transaction ends either on mem_ready or when the counter has expired;
  // mem_ready in the expiry cycle still counts as a normal completion.
  assign done      = (state_q == BUSY) && (mem_ready || timer_expired);
  assign timed_out = !mem_ready;
  assign done_data = mem_ready ? mem_rdata : '0;

  // ---------------------------------------------------------------------
  // Next-state and registered outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    cpu_err_d   = 1'b0;
    dbg_err_d   = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = BUSY;
          owner_d     = win;
          timer_clear = 1'b1;
          if (win == OWN_DBG) begin
            mem_we_d    = dbg_we;
            mem_addr_d  = dbg_addr;
            mem_wdata_d = dbg_wdata;
          end else begin
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end
        end
      end

      BUSY: begin
        if (done) begin
          state_d = ACK;
          if (owner_q == OWN_DBG) begin
            dbg_ack_d = 1'b1;
            dbg_err_d = timed_out;
            if (!mem_we_q) dbg_rdata_d = done_data;
          end else begin
            cpu_ack_d = 1'b1;
            cpu_err_d = timed_out;
            if (!mem_we_q) cpu_rdata_d = done_data;
          end
        end else begin
          timer_en = 1'b1;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    mem_en_d = (state_d == BUSY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      dbg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_err_q   <= cpu_err_d;
      dbg_err_q   <= dbg_err_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_err   = cpu_err_q;
  assign dbg_err   = dbg_err_q;
  assign state_dbg = state_q;

endmodule
